pchip_push: RTL and testbench

//  Frame-push stage downstream of the pchip controller. It starts on fire_pcpush
//  and reads NWORD payload words from the packet buffer through a 1-cycle-latency

---
 rtl/pchip_push_if.sv | 27 ++
 rtl/pchip_push.sv | 87 ++++++++
 tb/tb_pchip_push.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pchip_push_if.sv
// Frame-push bus: controller handshake, buffer read port and output stream.
interface pchip_push_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          fire_pcpush;
  logic          done_pcpush;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] push_data;
  logic          push_vld;
  logic          push_rdy;

  // master: the push stage itself
  modport master (
    input  fire_pcpush, rd_data, push_rdy,
    output done_pcpush, busy, rd_en, rd_addr, push_data, push_vld
  );

  // slave: controller, packet buffer and downstream sink
  modport slave (
    output fire_pcpush, rd_data, push_rdy,
    input  done_pcpush, busy, rd_en, rd_addr, push_data, push_vld
  );
endinterface

// File: rtl/pchip_push.sv
// Frame-push stage: streams HEADER, NWORD buffer words and a wrapping checksum,
// then pulses done_pcpush. Every output decodes from registered state only, so
// push_rdy only steers the next state.
module pchip_push #(
  parameter int             DW     = 16,
  parameter int             AW     = 8,
  parameter int             NWORD  = 64,
  parameter logic [DW-1:0]  HEADER = 16'hEB90
) (
  input  logic         clk_sys,
  input  logic         rst,
  pchip_push_if.master bus
);
  typedef enum logic [2:0] {IDLE, HEAD, FETCH, LOAD, SEND, CSUM, DONE} state_t;

  // Last payload index; NWORD = 2^AW makes this all-ones, so idx never wraps.
  localparam logic [AW-1:0] LAST = AW'(NWORD - 1);

  state_t        state, state_nx;
  logic [AW-1:0] idx;
  logic [DW-1:0] sum;
  logic [DW-1:0] word;
  logic          xfer;

  assign xfer = bus.push_vld & bus.push_rdy;

  // Outputs decoded from the state register and datapath registers.
  assign bus.busy        = (state != IDLE);
  assign bus.push_vld    = (state == HEAD) || (state == SEND) || (state == CSUM);
  assign bus.rd_en       = (state == FETCH);
  assign bus.rd_addr     = (state == FETCH) ? idx : '0;
  assign bus.done_pcpush = (state == DONE);

  // Stream word mux: header, captured payload word or running checksum.
  always_comb begin
    bus.push_data = '0;
    case (state)
      HEAD:    bus.push_data = HEADER;
      SEND:    bus.push_data = word;
      CSUM:    bus.push_data = sum;
      default: bus.push_data = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; stream states hold until the word is accepted.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.fire_pcpush) state_nx = HEAD;
      HEAD:    if (xfer) state_nx = FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    if (xfer) state_nx = (idx == LAST) ? CSUM : FETCH;
      CSUM:    if (xfer) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Word index, captured payload word and checksum accumulator.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      idx  <= '0;
      sum  <= '0;
      word <= '0;
    end else begin
      case (state)
        IDLE: if (bus.fire_pcpush) begin
          idx <= '0;
          sum <= '0;
        end
        LOAD: begin
          word <= bus.rd_data;
          sum  <= sum + bus.rd_data;
        end
        SEND: if (xfer && (idx != LAST)) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pchip_push.sv
// Bench for pchip_push: frame-level model (expected word queue, read-address
// counter, done timing) checked every cycle, plus literal expectations.
module tb_pchip_push;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;

  always #5 clk = ~clk;

  pchip_push_if #(.DW(16), .AW(8)) pif ();
  pchip_push_if #(.DW(16), .AW(2)) pif2 ();

  pchip_push #(.DW(16), .AW(8), .NWORD(4), .HEADER(16'hEB90)) dut (
    .clk_sys(clk), .rst(rst), .bus(pif.master));
  pchip_push #(.DW(16), .AW(2), .NWORD(4), .HEADER(16'hEB90)) dut2 (
    .clk_sys(clk), .rst(rst), .bus(pif2.master));

  logic [15:0] mem  [256];
  logic [15:0] mem2 [4];

  // Packet buffers with one cycle of read latency.
  always @(posedge clk) begin
    if (pif.rd_en)  pif.rd_data  <= mem[pif.rd_addr];
    if (pif2.rd_en) pif2.rd_data <= mem2[pif2.rd_addr];
  end

  // Model state.
  bit          m_active, m_due, m_hold, rst_prev;
  logic [15:0] m_hold_data;
  logic [15:0] m_q [$];
  int          m_addr, m_reads, n_done, fire_cnt, done_cnt;
  logic [15:0] got [$];
  int          addr_log [$];
  logic [15:0] got2 [$];
  int          addr2 [$];
  int          n_done2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  // Compare DUT outputs (after edge cnt) against the model; inputs now on the
  // pins are what the next edge will sample.
  task automatic model_check();
    bit was_active = m_active;
    logic [15:0] s;
    if (rst_prev) begin
      chk("post_rst_outputs",
          {pif.busy, pif.push_vld, pif.done_pcpush, pif.rd_en, pif.push_data, 8'(pif.rd_addr)}, 0);
    end else begin
      chk("done", pif.done_pcpush, m_due);
      chk("busy", pif.busy, was_active);
      if (m_due) begin
        chk("reads_per_frame", m_reads, 4);
        chk("words_left", m_q.size(), 0);
        n_done++;
        done_cnt = cnt;
        m_active = 1'b0;
        m_due    = 1'b0;
      end
      if (!was_active) chk("vld_idle", pif.push_vld, 1'b0);
      if (m_hold) chk("hold_stable", {pif.push_vld, pif.push_data}, {1'b1, m_hold_data});
      if (pif.rd_en) begin
        chk("rd_context", {was_active, pif.push_vld}, 2'b10);
        chk("rd_addr", pif.rd_addr, m_addr);
        addr_log.push_back(int'(pif.rd_addr));
        m_addr++;
        m_reads++;
      end
      if (pif.push_vld) begin
        if (m_q.size() == 0) chk("push_extra", 1'b1, 1'b0);
        else                 chk("push_data", pif.push_data, m_q[0]);
      end
      if (pif.push_vld && pif.push_rdy && !rst) begin
        got.push_back(pif.push_data);
        if (m_q.size() != 0) void'(m_q.pop_front());
        if (m_q.size() == 0) m_due = 1'b1;
      end
      m_hold      = pif.push_vld && !pif.push_rdy;
      m_hold_data = pif.push_data;
    end
    if (pif.fire_pcpush && !was_active && !rst) begin
      m_q.delete();
      s = 16'h0;
      m_q.push_back(16'hEB90);
      for (int i = 0; i < 4; i++) begin
        m_q.push_back(mem[i]);
        s = s + mem[i];
      end
      m_q.push_back(s);
      m_active = 1'b1;
      m_addr   = 0;
      m_reads  = 0;
      fire_cnt = cnt;
    end
    if (rst) begin
      m_active = 1'b0;
      m_due    = 1'b0;
      m_hold   = 1'b0;
      m_q.delete();
    end
    rst_prev = rst;
    if (pif2.rd_en) addr2.push_back(int'(pif2.rd_addr));
    if (pif2.push_vld && pif2.push_rdy) got2.push_back(pif2.push_data);
    if (pif2.done_pcpush) n_done2++;
  endtask

  // One clock: drive inputs just after the edge, check at the falling edge.
  task automatic cyc(input bit f, input bit r, input bit s, input bit f2 = 1'b0);
    @(posedge clk);
    cnt++;
    #1;
    pif.fire_pcpush  = f;
    pif.push_rdy     = r;
    rst              = s;
    pif2.fire_pcpush = f2;
    @(negedge clk);
    model_check();
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1'b0, rnd ? ($urandom_range(0, 9) < 3) : 1'b1, 1'b0);
      if (!m_active && !m_due) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_timeout", ok, 1'b1);
  endtask

  task automatic load(input logic [15:0] a, b, c, d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  initial begin
    logic [15:0] exp1 [6];
    logic [15:0] exp5 [6];
    logic [15:0] exp6 [6];
    int g0, d0, a0;
    exp1 = '{16'hEB90, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A};
    exp5 = '{16'hEB90, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h001A};
    exp6 = '{16'hEB90, 16'h0010, 16'h0020, 16'h0030, 16'hFFF0, 16'h0050};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem2 = '{16'h0010, 16'h0020, 16'h0030, 16'hFFF0};
    rst = 1'b1;
    pif.fire_pcpush = 1'b0; pif.push_rdy = 1'b0;
    pif2.fire_pcpush = 1'b0; pif2.push_rdy = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("reset_state",
        {pif.busy, pif.push_vld, pif.done_pcpush, pif.rd_en, pif.push_data, pif.rd_addr}, 0);

    // 1: plain frame, ready held high
    load(16'h1, 16'h2, 16'h3, 16'h4);
    g0 = got.size(); d0 = n_done;
    cyc(1'b1, 1'b1, 1'b0);
    wait_idle(40, 1'b0);
    chk("t1_len", got.size() - g0, 6);
    for (int i = 0; i < 6; i++) chk("t1_word", got[g0 + i], exp1[i]);
    chk("t1_done_latency", done_cnt - fire_cnt, 15);
    chk("t1_one_done", n_done - d0, 1);

    // 2: same frame with random backpressure
    g0 = got.size(); d0 = n_done;
    cyc(1'b1, $urandom_range(0, 9) < 3, 1'b0);
    wait_idle(600, 1'b1);
    chk("t2_len", got.size() - g0, 6);
    for (int i = 0; i < 6; i++) chk("t2_word", got[g0 + i], exp1[i]);
    chk("t2_one_done", n_done - d0, 1);

    // 3: checksum wraps
    load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    g0 = got.size();
    cyc(1'b1, 1'b1, 1'b0);
    wait_idle(40, 1'b0);
    chk("t3_csum", got[g0 + 5], 16'hFFFC);

    // 4: fires mid-frame and in DONE are ignored
    load(16'h1, 16'h2, 16'h3, 16'h4);
    g0 = got.size(); d0 = n_done;
    cyc(1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 25; j++) cyc(j == 3 || j == 14 || j == 15, 1'b1, 1'b0);
    chk("t4_one_done", n_done - d0, 1);
    chk("t4_one_frame", got.size() - g0, 6);
    chk("t4_idle_after", pif.busy, 1'b0);

    // 5: reset during SEND of word 2, then a fresh frame
    d0 = n_done;
    cyc(1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 9; j++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t5_in_send_w2", {pif.push_vld, pif.push_data}, {1'b1, 16'h0003});
    cyc(1'b0, 1'b0, 1'b0);
    chk("t5_outputs_zero",
        {pif.busy, pif.push_vld, pif.done_pcpush, pif.rd_en, pif.push_data}, 0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    chk("t5_no_done", n_done - d0, 0);
    load(16'h5, 16'h6, 16'h7, 16'h8);
    g0 = got.size(); a0 = addr_log.size();
    cyc(1'b1, 1'b1, 1'b0);
    wait_idle(40, 1'b0);
    chk("t5_restart_addr0", addr_log[a0], 0);
    for (int i = 0; i < 6; i++) chk("t5_word", got[g0 + i], exp5[i]);

    // 6: AW=2 with NWORD=4 ends at address 3
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b1, 1'b0);
    chk("t6_reads", addr2.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6_addr", addr2[i], i);
    chk("t6_len", got2.size(), 6);
    for (int i = 0; i < 6; i++) chk("t6_word", got2[i], exp6[i]);
    chk("t6_one_done", n_done2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
